// File: rtl/fft_bram_reader.sv
// Drains one FFT frame from a BRAM read port onto a valid/ready stream.
// Credit-based issue keeps in-flight reads plus buffered words within the output FIFO depth.
module fft_bram_reader #(
   parameter int ADDR_W    = 3,
   parameter int DATA_W    = 16,
   parameter int NUM_WORDS = 8,
   parameter int FIFO_D    = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              flush,
   output logic [ADDR_W-1:0] bram_addr,
   input  logic [DATA_W-1:0] bram_q,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   localparam int PTR_W = $clog2(FIFO_D);
   localparam int CNT_W = PTR_W + 2;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
   localparam logic [CNT_W-1:0]  DEPTH     = CNT_W'(FIFO_D);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]        state;
   logic              rdVld;
   logic              rdLast;
   logic              capVld;
   logic              capLast;
   logic [DATA_W-1:0] capData;
   logic [DATA_W:0]   fifoMem [FIFO_D];
   logic [PTR_W-1:0]  wrPtr;
   logic [PTR_W-1:0]  rdPtr;
   logic [CNT_W-1:0]  fifoCount;
   logic [CNT_W-1:0]  credit;
   logic              atLast;
   logic              issue;
   logic              pop;
   logic              lastBeat;

   // Reads in the BRAM (rdVld) and in the capture register (capVld) both hold FIFO credit.
   always_comb begin
      atLast    = (bram_addr == LAST_ADDR);
      credit    = fifoCount + CNT_W'(rdVld) + CNT_W'(capVld);
      issue     = (state == READ) && (credit < DEPTH);
      out_valid = (fifoCount != '0);
      pop       = out_valid && out_ready;
      out_data  = out_valid ? fifoMem[rdPtr][DATA_W-1:0] : '0;
      out_last  = out_valid && fifoMem[rdPtr][DATA_W];
      lastBeat  = pop && out_last;
      busy      = (state != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         done      <= 1'b0;
         bram_addr <= '0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state     <= READ;
                     bram_addr <= '0;
                  end
               end
               READ: begin
                  if (issue) begin
                     bram_addr <= atLast ? bram_addr : bram_addr + ADDR_W'(1);
                     if (atLast) state <= DRAIN;
                  end
               end
               DRAIN: begin
                  if (lastBeat) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Read-latency pipe: BRAM output is registered once more before entering the FIFO.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdVld   <= 1'b0;
         rdLast  <= 1'b0;
         capVld  <= 1'b0;
         capLast <= 1'b0;
         capData <= '0;
      end else if (flush) begin
         rdVld  <= 1'b0;
         rdLast <= 1'b0;
         capVld <= 1'b0;
      end else begin
         rdVld   <= issue;
         rdLast  <= issue && atLast;
         capVld  <= rdVld;
         capLast <= rdLast;
         if (rdVld) capData <= bram_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         fifoCount <= '0;
      end else if (flush) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         fifoCount <= '0;
      end else begin
         if (capVld) wrPtr <= wrPtr + PTR_W'(1);
         if (pop)    rdPtr <= rdPtr + PTR_W'(1);
         fifoCount <= fifoCount + CNT_W'(capVld) - CNT_W'(pop);
      end
   end

   // Storage needs no reset: contents are only visible while the count says they are valid.
   always_ff @(posedge clk) begin
      if (capVld && !flush) fifoMem[wrPtr] <= {capLast, capData};
   end

endmodule

// File: tb/tb_fft_bram_reader.sv
// Directed bench for fft_bram_reader with a 1-cycle-latency BRAM model holding mem[i]=i.
module tb_fft_bram_reader;

   localparam int ADDR_W    = 3;
   localparam int DATA_W    = 16;
   localparam int NUM_WORDS = 8;
   localparam int FIFO_D    = 4;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start;
   logic              flush;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_q;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] mem [NUM_WORDS];

   int checks = 0;
   int errors = 0;

   fft_bram_reader #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS), .FIFO_D(FIFO_D)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .flush(flush),
      .bram_addr(bram_addr), .bram_q(bram_q),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) bram_q <= mem[bram_addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_last"},  32'(out_last),  32'd0);
      checkOutput({tag, "_data"},  32'(out_data),  32'd0);
      checkOutput({tag, "_busy"},  32'(busy),      32'd0);
      checkOutput({tag, "_done"},  32'(done),      32'd0);
   endtask

   task automatic applyStimulus();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Collects one frame under a repeating 4-cycle ready pattern; ends in the done cycle.
   task automatic drainFrame(input logic [3:0] pat, input string tag);
      int                expIdx = 0;
      int                doneCnt = 0;
      logic              stalled = 1'b0;
      logic [DATA_W-1:0] held = '0;
      for (int cyc = 0; cyc < 200 && expIdx < NUM_WORDS; cyc++) begin
         out_ready = pat[cyc % 4];
         if (stalled) checkOutput({tag, "_hold"}, 32'(out_data), 32'(held));
         if (done) doneCnt++;
         if (out_valid && out_ready) begin
            checkOutput({tag, "_beat"}, 32'(out_data), 32'(expIdx));
            checkOutput({tag, "_lastflag"}, 32'(out_last), 32'(expIdx == NUM_WORDS - 1));
            expIdx++;
         end
         stalled = out_valid && !out_ready;
         held    = out_data;
         tick();
      end
      checkOutput({tag, "_beats"},     32'(expIdx),    32'(NUM_WORDS));
      checkOutput({tag, "_earlydone"}, 32'(doneCnt),   32'd0);
      checkOutput({tag, "_done"},      32'(done),      32'd1);
      checkOutput({tag, "_busy"},      32'(busy),      32'd0);
      checkOutput({tag, "_valid"},     32'(out_valid), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] = DATA_W'(i);
      reset_n   = 1'b0;
      start     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      checkIdle("reset");
      checkOutput("reset_addr", 32'(bram_addr), 32'd0);
      reset_n = 1'b1;
      tick();

      $display("[TB] test 1: full-rate frame");
      applyStimulus();
      checkOutput("t1_busy", 32'(busy), 32'd1);
      checkOutput("t1_addr0", 32'(bram_addr), 32'd0);
      checkOutput("t1_valid_e0", 32'(out_valid), 32'd0);
      tick();
      checkOutput("t1_addr1", 32'(bram_addr), 32'd1);
      checkOutput("t1_valid_e1", 32'(out_valid), 32'd0);
      tick();
      checkOutput("t1_valid_e2", 32'(out_valid), 32'd0);
      tick();
      for (int k = 0; k < NUM_WORDS; k++) begin
         checkOutput("t1_valid", 32'(out_valid), 32'd1);
         checkOutput("t1_data", 32'(out_data), 32'(k));
         checkOutput("t1_last", 32'(out_last), 32'(k == NUM_WORDS - 1));
         checkOutput("t1_nodone", 32'(done), 32'd0);
         tick();
      end
      checkOutput("t1_done", 32'(done), 32'd1);
      checkOutput("t1_busy_end", 32'(busy), 32'd0);
      checkOutput("t1_valid_end", 32'(out_valid), 32'd0);
      checkOutput("t1_addr_park", 32'(bram_addr), 32'(NUM_WORDS - 1));
      tick();
      checkOutput("t1_done_pulse", 32'(done), 32'd0);

      $display("[TB] test 2: ready pattern 1,0,0,1");
      applyStimulus();
      drainFrame(4'b1001, "t2");
      tick();
      checkOutput("t2_done_pulse", 32'(done), 32'd0);

      $display("[TB] test 3: consumer stalled");
      out_ready = 1'b0;
      applyStimulus();
      repeat (10) tick();
      checkOutput("t3_addr_park", 32'(bram_addr), 32'd4);
      checkOutput("t3_valid", 32'(out_valid), 32'd1);
      checkOutput("t3_data", 32'(out_data), 32'd0);
      checkOutput("t3_busy", 32'(busy), 32'd1);
      drainFrame(4'b1111, "t3");
      tick();

      $display("[TB] test 4: flush mid-frame");
      out_ready = 1'b1;
      applyStimulus();
      begin
         logic found = 1'b0;
         for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            if (out_valid && out_data == DATA_W'(3)) found = 1'b1;
            else tick();
         end
         checkOutput("t4_beat3_seen", 32'(found), 32'd1);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("t4_valid", 32'(out_valid), 32'd0);
      checkOutput("t4_busy", 32'(busy), 32'd0);
      checkOutput("t4_done", 32'(done), 32'd0);
      repeat (5) begin
         tick();
         checkOutput("t4_nodone", 32'(done), 32'd0);
         checkOutput("t4_novalid", 32'(out_valid), 32'd0);
      end
      applyStimulus();
      checkOutput("t4_restart_addr", 32'(bram_addr), 32'd0);
      drainFrame(4'b1111, "t4");
      tick();

      $display("[TB] test 5: async reset and ignored start");
      applyStimulus();
      repeat (3) tick();
      checkOutput("t5_valid_before", 32'(out_valid), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      checkIdle("t5_async");
      checkOutput("t5_async_addr", 32'(bram_addr), 32'd0);
      tick();
      reset_n = 1'b1;
      checkIdle("t5_released");
      tick();
      applyStimulus();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      drainFrame(4'b1111, "t5");
      repeat (6) begin
         tick();
         checkOutput("t5_single_done", 32'(done), 32'd0);
         checkOutput("t5_single_busy", 32'(busy), 32'd0);
      end

      $display("[TB] test 6: back-to-back frames");
      applyStimulus();
      drainFrame(4'b1111, "t6a");
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("t6_restart_busy", 32'(busy), 32'd1);
      checkOutput("t6_restart_addr", 32'(bram_addr), 32'd0);
      drainFrame(4'b1111, "t6b");
      checkOutput("t6_top_addr", 32'(bram_addr), 32'(NUM_WORDS - 1));
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
